// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider (signed/unsigned) with valid/ready request and response handshakes.
// Optional early retirement when |x| < |y| is enabled by defining ITER_DIVIDER_EARLY_OUT_EN.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    input  logic             cancel,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_q,
    output logic [WIDTH-1:0] resp_r,
    output logic             resp_dbz
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] x_raw;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   rem;
    logic [CNT_W-1:0] cnt;
    logic             q_neg;
    logic             r_neg;
    logic             y_zero;

    logic             accept;
    logic             x_neg;
    logic             y_neg;
    logic             early_out;
    logic             fits;
    logic [WIDTH-1:0] x_abs;
    logic [WIDTH-1:0] y_abs;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;

    assign req_ready  = (state == IDLE) & ~cancel;
    assign resp_valid = (state == DONE);
    assign accept     = req_valid & req_ready;

    always_comb begin
        x_neg     = req_signed & req_x[WIDTH-1];
        y_neg     = req_signed & req_y[WIDTH-1];
        x_abs     = x_neg ? -req_x : req_x;
        y_abs     = y_neg ? -req_y : req_y;
        // quo doubles as the dividend shift register: its MSB feeds the remainder
        rem_shift = (rem << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, y_mag};
        fits      = (rem_shift >= {1'b0, y_mag});
`ifdef ITER_DIVIDER_EARLY_OUT_EN
        early_out = (y_abs != '0) && (x_abs < y_abs);
`else
        early_out = 1'b0;
`endif
    end

    always_comb begin
        state_next = state;
        if (cancel) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_next = early_out ? FIX : CALC;
                CALC: if (cnt == LAST_ITER) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: if (resp_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_raw    <= '0;
            y_mag    <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            y_zero   <= 1'b0;
            resp_q   <= '0;
            resp_r   <= '0;
            resp_dbz <= 1'b0;
        end else if (!cancel) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_raw  <= req_x;
                        y_mag  <= y_abs;
                        q_neg  <= x_neg ^ y_neg;
                        r_neg  <= x_neg;
                        y_zero <= (req_y == '0);
                        cnt    <= '0;
                        if (early_out) begin
                            quo <= '0;
                            rem <= {1'b0, x_abs};
                        end else begin
                            quo <= x_abs;
                            rem <= '0;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    quo <= {quo[WIDTH-2:0], fits};
                    rem <= fits ? rem_sub : rem_shift;
                end
                FIX: begin
                    resp_dbz <= y_zero;
                    if (y_zero) begin
                        resp_q <= '1;
                        resp_r <= x_raw;
                    end else begin
                        resp_q <= q_neg ? -quo : quo;
                        resp_r <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
